// File: rtl/reglist_encoder_if.sv
// Handshake and data bundle between the LDM/STM register-list encoder and
// the load/store unit that requests sequences and consumes the beats.
interface reglist_encoder_if;
    logic        start;
    logic [15:0] reglist;
    logic        ready;
    logic        busy;
    logic        valid;
    logic [3:0]  regnum;
    logic [3:0]  beat;
    logic        first;
    logic        last;
    logic [4:0]  count;
    logic        done;

    // Load/store side: requests sequences and accepts beats.
    modport master (
        output start, reglist, ready,
        input  busy, valid, regnum, beat, first, last, count, done
    );

    // Encoder side.
    modport slave (
        input  start, reglist, ready,
        output busy, valid, regnum, beat, first, last, count, done
    );
endinterface

// File: rtl/reglist_encoder.sv
// Sequential 16-to-4 register-list encoder. Latches an ARM register list and
// emits the set register numbers lowest first, one per accepted beat.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; start captures reglist
// ISSUE  | presenting the lowest pending register, waiting for ready
// FINISH | one-cycle done pulse, then back to IDLE
module reglist_encoder (
    input  logic               clk,
    input  logic               reset,
    reglist_encoder_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] pending_q;
    logic [3:0]  beat_q;
    logic [4:0]  count_q;

    logic [3:0]  low_idx;
    logic [4:0]  list_ones;
    logic        pending_single;
    logic        load;
    logic        accept;

    // Index of the lowest set bit of the pending mask; bit 0 has priority.
    always_comb begin
        low_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pending_q[i]) begin
                low_idx = 4'(i);
            end
        end
    end

    // Population count of the incoming list, captured on an accepted start.
    always_comb begin
        list_ones = 5'd0;
        for (int i = 0; i < 16; i++) begin
            list_ones = list_ones + {4'd0, bus.reglist[i]};
        end
    end

    // Exactly one bit left means the beat being presented is the final one.
    assign pending_single = (pending_q != 16'd0) &&
                            ((pending_q & (pending_q - 16'd1)) == 16'd0);

    assign load   = (state_q == IDLE) && bus.start;
    assign accept = (state_q == ISSUE) && bus.ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = (bus.reglist != 16'd0) ? ISSUE : FINISH;
                end
            end
            ISSUE: begin
                if (bus.ready && pending_single) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: capture the list on start, retire the lowest bit per beat.
    // Clearing the lowest set bit with p & (p-1) avoids a decoder on low_idx.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= 16'd0;
            beat_q    <= 4'd0;
            count_q   <= 5'd0;
        end else if (load) begin
            pending_q <= bus.reglist;
            beat_q    <= 4'd0;
            count_q   <= list_ones;
        end else if (accept) begin
            pending_q <= pending_q & (pending_q - 16'd1);
            beat_q    <= beat_q + 4'd1;
        end
    end

    // Outputs depend on registered state only; beat-related fields are
    // forced to zero outside ISSUE so the consumer never sees stale values.
    assign bus.busy   = (state_q != IDLE);
    assign bus.valid  = (state_q == ISSUE);
    assign bus.done   = (state_q == FINISH);
    assign bus.regnum = (state_q == ISSUE) ? low_idx : 4'd0;
    assign bus.first  = (state_q == ISSUE) && (beat_q == 4'd0);
    assign bus.last   = (state_q == ISSUE) && pending_single;
    assign bus.beat   = beat_q;
    assign bus.count  = count_q;

endmodule

// File: tb/tb_reglist_encoder.sv
// Self-checking bench for reglist_encoder: directed scenarios plus randomized
// lists and backpressure checked against a list-of-set-bits reference model.
module tb_reglist_encoder;

    logic clk = 1'b0;
    logic reset;
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    reglist_encoder_if bus ();

    reglist_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Advance one cycle; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: ascending list of set bit positions.
    function automatic void set_bits(input logic [15:0] list, output int q[$]);
        q = {};
        for (int i = 0; i < 16; i++) begin
            if (list[i]) q.push_back(i);
        end
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.reglist = 16'h0;
        bus.ready = 1'b0;
        tick();
        tick();
        total_cnt++;
        if ({bus.busy, bus.valid, bus.regnum, bus.beat, bus.first, bus.last,
             bus.count, bus.done} !== 18'd0)
            $display("FAIL reset_outputs busy=%b valid=%b regnum=%0d beat=%0d first=%b last=%b count=%0d done=%b expected all 0",
                     bus.busy, bus.valid, bus.regnum, bus.beat, bus.first, bus.last, bus.count, bus.done);
        else pass_cnt++;
        reset = 1'b0;
        tick();
    endtask

    // Runs one full sequence starting from IDLE. ready_pct sets the chance
    // of ready per cycle; noise pulses start with random lists while busy.
    task automatic run_sequence(input logic [15:0] list, input int ready_pct,
                                input bit noise, input string tag);
        int exp_q[$];
        int n;
        int idx;
        int cyc;
        bit rdy;
        set_bits(list, exp_q);
        n = exp_q.size();
        bus.start = 1'b1;
        bus.reglist = list;
        bus.ready = 1'b0;
        tick();
        bus.start = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < n) begin
            total_cnt++;
            if (bus.valid !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0 ||
                bus.regnum !== 4'(exp_q[idx]) || bus.beat !== 4'(idx) ||
                bus.first !== (idx == 0) || bus.last !== (idx == n - 1) ||
                bus.count !== 5'(n))
                $display("FAIL %s_beat%0d valid=%b busy=%b done=%b regnum=%0d beat=%0d first=%b last=%b count=%0d expected valid=1 busy=1 done=0 regnum=%0d beat=%0d first=%b last=%b count=%0d",
                         tag, idx, bus.valid, bus.busy, bus.done, bus.regnum, bus.beat,
                         bus.first, bus.last, bus.count, exp_q[idx], idx & 15,
                         idx == 0, idx == n - 1, n);
            else pass_cnt++;
            rdy = ($urandom_range(0, 99) < ready_pct);
            bus.ready = rdy;
            if (noise) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.reglist = 16'($urandom);
            end
            tick();
            if (rdy) idx++;
            cyc++;
            if (cyc > 2000) begin
                total_cnt++;
                $display("FAIL %s_timeout sequence did not complete in 2000 cycles", tag);
                bus.start = 1'b0;
                return;
            end
        end
        bus.start = 1'b0;
        bus.ready = 1'b0;
        total_cnt++;
        if (bus.valid !== 1'b0 || bus.done !== 1'b1 || bus.busy !== 1'b1 ||
            bus.count !== 5'(n) || bus.beat !== 4'(n) || bus.regnum !== 4'd0 ||
            bus.first !== 1'b0 || bus.last !== 1'b0)
            $display("FAIL %s_finish valid=%b done=%b busy=%b count=%0d beat=%0d regnum=%0d first=%b last=%b expected 0 1 1 %0d %0d 0 0 0",
                     tag, bus.valid, bus.done, bus.busy, bus.count, bus.beat,
                     bus.regnum, bus.first, bus.last, n, n & 15);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.valid !== 1'b0 ||
            bus.count !== 5'(n))
            $display("FAIL %s_idle busy=%b done=%b valid=%b count=%0d expected 0 0 0 %0d",
                     tag, bus.busy, bus.done, bus.valid, bus.count, n);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        run_sequence(16'h8421, 100, 1'b0, "list8421");
    endtask

    task automatic test_full_list();
        run_sequence(16'hFFFF, 100, 1'b0, "listFFFF");
    endtask

    task automatic test_empty_list();
        run_sequence(16'h0000, 100, 1'b0, "empty");
    endtask

    task automatic test_backpressure();
        bus.start = 1'b1;
        bus.reglist = 16'h0006;
        bus.ready = 1'b0;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (bus.valid !== 1'b1 || bus.regnum !== 4'd1 || bus.beat !== 4'd0 ||
                bus.first !== 1'b1 || bus.last !== 1'b0)
                $display("FAIL bp_stall%0d valid=%b regnum=%0d beat=%0d first=%b last=%b expected 1 1 0 1 0",
                         i, bus.valid, bus.regnum, bus.beat, bus.first, bus.last);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (bus.valid !== 1'b1 || bus.regnum !== 4'd1)
            $display("FAIL bp_held valid=%b regnum=%0d expected 1 1", bus.valid, bus.regnum);
        else pass_cnt++;
        bus.ready = 1'b1;
        tick();
        total_cnt++;
        if (bus.valid !== 1'b1 || bus.regnum !== 4'd2 || bus.last !== 1'b1 ||
            bus.first !== 1'b0 || bus.beat !== 4'd1)
            $display("FAIL bp_second valid=%b regnum=%0d last=%b first=%b beat=%0d expected 1 2 1 0 1",
                     bus.valid, bus.regnum, bus.last, bus.first, bus.beat);
        else pass_cnt++;
        tick();
        bus.ready = 1'b0;
        total_cnt++;
        if (bus.done !== 1'b1 || bus.valid !== 1'b0 || bus.count !== 5'd2)
            $display("FAIL bp_done done=%b valid=%b count=%0d expected 1 0 2",
                     bus.done, bus.valid, bus.count);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_start_ignored();
        bus.start = 1'b1;
        bus.reglist = 16'h0003;
        bus.ready = 1'b1;
        tick();
        total_cnt++;
        if (bus.regnum !== 4'd0 || bus.valid !== 1'b1 || bus.count !== 5'd2)
            $display("FAIL ign_beat0 regnum=%0d valid=%b count=%0d expected 0 1 2",
                     bus.regnum, bus.valid, bus.count);
        else pass_cnt++;
        bus.start = 1'b1;
        bus.reglist = 16'h00F0;
        tick();
        bus.start = 1'b0;
        total_cnt++;
        if (bus.regnum !== 4'd1 || bus.last !== 1'b1 || bus.count !== 5'd2 ||
            bus.beat !== 4'd1)
            $display("FAIL ign_beat1 regnum=%0d last=%b count=%0d beat=%0d expected 1 1 2 1",
                     bus.regnum, bus.last, bus.count, bus.beat);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.done !== 1'b1 || bus.valid !== 1'b0 || bus.count !== 5'd2)
            $display("FAIL ign_done done=%b valid=%b count=%0d expected 1 0 2",
                     bus.done, bus.valid, bus.count);
        else pass_cnt++;
        bus.ready = 1'b0;
        tick();
        total_cnt++;
        if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.count !== 5'd2)
            $display("FAIL ign_idle busy=%b valid=%b count=%0d expected 0 0 2",
                     bus.busy, bus.valid, bus.count);
        else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        bus.start = 1'b1;
        bus.reglist = 16'h00FF;
        bus.ready = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        total_cnt++;
        if (bus.regnum !== 4'd2 || bus.beat !== 4'd2)
            $display("FAIL abort_pre regnum=%0d beat=%0d expected 2 2", bus.regnum, bus.beat);
        else pass_cnt++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total_cnt++;
        if ({bus.busy, bus.valid, bus.regnum, bus.beat, bus.first, bus.last,
             bus.count, bus.done} !== 18'd0)
            $display("FAIL abort_outputs busy=%b valid=%b regnum=%0d beat=%0d first=%b last=%b count=%0d done=%b expected all 0",
                     bus.busy, bus.valid, bus.regnum, bus.beat, bus.first, bus.last, bus.count, bus.done);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.done !== 1'b0 || bus.valid !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL abort_quiet done=%b valid=%b busy=%b expected 0 0 0",
                     bus.done, bus.valid, bus.busy);
        else pass_cnt++;
        bus.ready = 1'b0;
        run_sequence(16'h0100, 100, 1'b0, "after_abort");
    endtask

    // Random lists, random backpressure and spurious starts, back to back.
    task automatic test_back_to_back();
        logic [15:0] list;
        for (int t = 0; t < 24; t++) begin
            case (t % 3)
                0: list = 16'($urandom);
                1: list = 16'($urandom) & 16'($urandom) & 16'($urandom);
                default: list = 16'(1 << $urandom_range(0, 15));
            endcase
            run_sequence(list, $urandom_range(30, 100), (t % 2) == 1, $sformatf("rand%0d", t));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_list();
        test_empty_list();
        test_backpressure();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/reglist_encoder.md
# reglist_encoder

Sequential 16-to-4 register-list encoder for the LDM/STM path. It is the inverse of the 4x16 register-select decoder. It latches a 16-bit ARM register list and emits the set register numbers one at a time, lowest first, under a valid/ready handshake. The load/store unit consumes the numbers to drive the register-file select decoder, and uses the beat index for address offsets.

## Interface
Parameters: none; widths are fixed by the ARM register file (16 registers).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  capture `reglist` and begin a sequence; ignored while `busy`=1
- reglist  in  16  bit i set = register Ri is in the transfer list
- ready  in  1  consumer accepts the current beat this cycle
- busy  out  1  a sequence is in progress
- valid  out  1  `regnum` holds a beat not yet accepted
- regnum  out  4  register number of the current beat
- beat  out  4  zero-based index of the current beat; address offset = `beat`×4
- first  out  1  current beat is beat 0
- last  out  1  current beat is the final set bit
- count  out  5  number of set bits in the latched list, 0..16
- done  out  1  one-cycle pulse when a sequence ends

## Operation
- Internal state: 16-bit `pending` mask, 4-bit `beat` counter, 5-bit `count`, and an FSM with states IDLE, ISSUE and FINISH.
- IDLE:
  - `start`=1 → `pending`←`reglist`, `count`←popcount(`reglist`), `beat`←0.
  - Next state is ISSUE if `reglist`≠0, otherwise FINISH.
- ISSUE:
  - `valid`=1. `regnum` = index of the lowest set bit of `pending`, priority from bit 0 upward.
  - `last` = exactly one bit set in `pending`. `first` = (`beat`==0).
  - `valid`&&`ready` → clear the `regnum` bit in `pending`, `beat`←`beat`+1.
  - Accepting the beat with `last`=1 → FINISH.
  - `ready`=0 → all outputs hold stable.
- FINISH: `done`=1 for exactly one cycle, then → IDLE.
- `busy` = (state ≠ IDLE).
- Empty list (`reglist`=0): no beats are emitted; `count`=0; `done` still pulses. Architecturally unpredictable, but the block's behaviour here is defined as stated.
- `start` while `busy`: ignored. `pending`, `count` and `beat` are unaffected.
- `count` holds its value after the sequence until the next accepted `start`. `beat` wraps modulo 16: after 16 beats it reads 0, and `count`=16 disambiguates.
- Outside ISSUE: `regnum`, `first` and `last` read 0.

## Timing
- Reset (synchronous): state=IDLE, `pending`=0, `beat`=0, `count`=0. Every output is 0: `busy`, `valid`, `regnum`, `first`, `last`, `done`.
- Reset asserted mid-sequence aborts it on the next edge. No `done` pulse and no further beats.
- Start latency:
  - `start` sampled at edge N → `busy`=1 and `valid`=1 from cycle N+1, with the first `regnum` valid in cycle N+1.
  - For an empty list: `done`=1 in cycle N+1, IDLE again in cycle N+2.
- Throughput: one beat per cycle while `ready`=1. A beat accepted at edge k → next `regnum` presented in cycle k+1.
- Final beat accepted at edge k → `valid`=0 and `done`=1 in cycle k+1. `busy` stays 1 through cycle k+1 and is 0 in cycle k+2.
- Back-to-back: the earliest accepted `start` is in cycle k+2.
- Total for n set bits with `ready` held high: n+1 cycles from the `start` edge to the `done` cycle inclusive.
- All outputs are functions of registered state only. There are no combinational paths from `start`, `reglist` or `ready` to any output.

## Test plan
- After reset, check all outputs are 0. Then `start` with `reglist`=16'h8421 and `ready`=1.
  - Expect `regnum` 0,5,10,15 on consecutive cycles, with `beat` 0..3.
  - Expect `first` on beat 0 only and `last` on beat 3 only, with `count`=4.
  - Expect `done` one cycle after beat 3.
- `reglist`=16'hFFFF, `ready`=1 → 16 beats, `regnum` 0..15, `count`=16, `beat` wraps to 0 after beat 15, `done` after 16 beats.
- `reglist`=16'h0000 → no `valid`, `count`=0, `done` in cycle N+1, `busy` low in cycle N+2.
- Backpressure with `reglist`=16'h0006:
  - Hold `ready`=0 for 3 cycles → `regnum`=1, `beat`=0, `valid`=1 stable throughout.
  - Then `ready`=1 → `regnum`=2 with `last`=1, then `done`.
- `start` with `reglist`=16'h00F0 pulsed mid-sequence of 16'h0003 → ignored. The output sequence is 0,1 only, and `count` stays 2.
- Reset asserted after the second beat of 16'h00FF → next cycle all outputs 0 and no `done`. A new `start` with 16'h0100 → single beat `regnum`=8 with `first`=`last`=1.
